barrel_thread_sched: RTL and testbench

Issue controller for the barrel pipeline. It selects which hardware thread fetches each cycle using round-robin over eligible threads, and holds the per-thread PC table. It tracks in-flight instructions so a thread never has two instructions in the pipeline. It also generates the global stall and writeback-bubble controls that drive the `en`/`clr` inputs of the F/D, D/E, E/M and M/W pipeline registers.

---
 rtl/barrel_thread_sched.sv | 100 ++++++++++
 tb/tb_barrel_thread_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/barrel_thread_sched.sv
// Barrel-pipeline issue controller: round-robin thread select over eligible threads,
// per-thread PC table, in-flight tracking, and global stall / W-bubble generation.
module barrel_thread_sched #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BITS_THREADS  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          thread_start_i,
  input  logic [BITS_THREADS-1:0]       thread_start_tid_i,
  input  logic [ADDRESS_WIDTH-1:0]      thread_start_pc_i,
  input  logic                          thread_halt_i,
  input  logic [BITS_THREADS-1:0]       thread_halt_tid_i,
  input  logic                          branch_taken_e_i,
  input  logic [BITS_THREADS-1:0]       branch_tid_e_i,
  input  logic [ADDRESS_WIDTH-1:0]      branch_target_e_i,
  input  logic                          wb_valid_i,
  input  logic [BITS_THREADS-1:0]       wb_tid_i,
  input  logic                          mem_req_m_i,
  input  logic                          mem_ready_i,
  output logic                          fetch_valid_o,
  output logic [BITS_THREADS-1:0]       fetch_tid_o,
  output logic [ADDRESS_WIDTH-1:0]      fetch_pc_o,
  output logic                          stall_o,
  output logic                          flush_w_o,
  output logic [(2**BITS_THREADS)-1:0]  thread_active_o
);

  localparam int NUM_THREADS = 2 ** BITS_THREADS;

  logic [NUM_THREADS-1:0]   active;
  logic [NUM_THREADS-1:0]   busy;
  logic [ADDRESS_WIDTH-1:0] pc [NUM_THREADS];
  logic [BITS_THREADS-1:0]  last_tid;

  logic [NUM_THREADS-1:0]   eligible;
  logic [BITS_THREADS-1:0]  cand;
  logic [BITS_THREADS-1:0]  sel;
  logic                     found;
  logic                     stall;
  logic                     issue;

  assign eligible = active & ~busy;
  assign stall    = mem_req_m_i & ~mem_ready_i;
  assign issue    = found & ~stall;

  // Search starts one past the last issuer; the narrow add wraps modulo NUM_THREADS.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      cand = last_tid + BITS_THREADS'(i);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= '0;
      busy     <= '0;
      last_tid <= '1;
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc[t] <= '0;
      end
    end else begin
      if (wb_valid_i) begin
        busy[wb_tid_i] <= 1'b0;
      end
      if (issue) begin
        busy[sel] <= 1'b1;
        pc[sel]   <= pc[sel] + ADDRESS_WIDTH'(4);
        last_tid  <= sel;
      end
      // A redirected thread is in flight, so it never collides with the issue increment.
      if (branch_taken_e_i) begin
        pc[branch_tid_e_i] <= branch_target_e_i;
      end
      if (thread_start_i && !active[thread_start_tid_i]) begin
        active[thread_start_tid_i] <= 1'b1;
        busy[thread_start_tid_i]   <= 1'b0;
        pc[thread_start_tid_i]     <= thread_start_pc_i;
      end
      if (thread_halt_i) begin
        active[thread_halt_tid_i] <= 1'b0;
      end
    end
  end

  assign fetch_valid_o   = issue;
  assign fetch_tid_o     = issue ? sel : '0;
  assign fetch_pc_o      = issue ? pc[sel] : '0;
  assign stall_o         = stall;
  assign flush_w_o       = stall;
  assign thread_active_o = active;

endmodule

// File: tb/tb_barrel_thread_sched.sv
// Directed self-checking bench for barrel_thread_sched.
module tb_barrel_thread_sched;

  logic        clk;
  logic        rst_n;
  logic        thread_start_i;
  logic [2:0]  thread_start_tid_i;
  logic [31:0] thread_start_pc_i;
  logic        thread_halt_i;
  logic [2:0]  thread_halt_tid_i;
  logic        branch_taken_e_i;
  logic [2:0]  branch_tid_e_i;
  logic [31:0] branch_target_e_i;
  logic        wb_valid_i;
  logic [2:0]  wb_tid_i;
  logic        mem_req_m_i;
  logic        mem_ready_i;
  logic        fetch_valid_o;
  logic [2:0]  fetch_tid_o;
  logic [31:0] fetch_pc_o;
  logic        stall_o;
  logic        flush_w_o;
  logic [7:0]  thread_active_o;

  int checks;
  int failures;
  logic [31:0] mpc [8];

  barrel_thread_sched #(.ADDRESS_WIDTH(32), .BITS_THREADS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .thread_start_i(thread_start_i), .thread_start_tid_i(thread_start_tid_i),
    .thread_start_pc_i(thread_start_pc_i),
    .thread_halt_i(thread_halt_i), .thread_halt_tid_i(thread_halt_tid_i),
    .branch_taken_e_i(branch_taken_e_i), .branch_tid_e_i(branch_tid_e_i),
    .branch_target_e_i(branch_target_e_i),
    .wb_valid_i(wb_valid_i), .wb_tid_i(wb_tid_i),
    .mem_req_m_i(mem_req_m_i), .mem_ready_i(mem_ready_i),
    .fetch_valid_o(fetch_valid_o), .fetch_tid_o(fetch_tid_o), .fetch_pc_o(fetch_pc_o),
    .stall_o(stall_o), .flush_w_o(flush_w_o), .thread_active_o(thread_active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    thread_start_i   = 1'b0;
    thread_halt_i    = 1'b0;
    branch_taken_e_i = 1'b0;
    wb_valid_i       = 1'b0;
  endtask

  task automatic start(input logic [2:0] tid, input logic [31:0] spc);
    thread_start_i     = 1'b1;
    thread_start_tid_i = tid;
    thread_start_pc_i  = spc;
  endtask

  task automatic retire(input logic [2:0] tid);
    wb_valid_i = 1'b1;
    wb_tid_i   = tid;
  endtask

  task automatic expect_issue(input string tag, input logic [2:0] tid, input logic [31:0] epc);
    #1;
    chk({tag, "_valid"}, 32'(fetch_valid_o), 32'd1);
    chk({tag, "_tid"}, 32'(fetch_tid_o), 32'(tid));
    chk({tag, "_pc"}, fetch_pc_o, epc);
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, "_valid"}, 32'(fetch_valid_o), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    thread_start_i = 1'b0; thread_start_tid_i = '0; thread_start_pc_i = '0;
    thread_halt_i = 1'b0; thread_halt_tid_i = '0;
    branch_taken_e_i = 1'b0; branch_tid_e_i = '0; branch_target_e_i = '0;
    wb_valid_i = 1'b0; wb_tid_i = '0;
    mem_req_m_i = 1'b1; mem_ready_i = 1'b0;

    // Reset state; stall/flush follow inputs even in reset
    @(posedge clk);
    #2;
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_tid", 32'(fetch_tid_o), 32'd0);
    chk("rst_pc", fetch_pc_o, 32'd0);
    chk("rst_active", 32'(thread_active_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd1);
    chk("rst_flush", 32'(flush_w_o), 32'd1);
    mem_req_m_i = 1'b0;
    #1;
    chk("rst_stall_lo", 32'(stall_o), 32'd0);
    #2;
    rst_n = 1'b1;

    // Two threads, busy blocks re-issue until retire
    next(); start(3'd0, 32'h100);  expect_idle("s1");
    next(); start(3'd3, 32'h200);  expect_issue("s2", 3'd0, 32'h100);
    next();                        expect_issue("s3", 3'd3, 32'h200);
    next();                        expect_idle("s4");
    next(); retire(3'd0);          expect_idle("s5");
    next();                        expect_issue("s6", 3'd0, 32'h104);
    next(); retire(3'd3);          expect_idle("s7");
    next(); retire(3'd0);          expect_issue("s8", 3'd3, 32'h204);
    next();                        expect_issue("s9", 3'd0, 32'h108);

    // Halt+start same tid: halt wins; start to active thread ignored
    next(); start(3'd1, 32'h300); thread_halt_i = 1'b1; thread_halt_tid_i = 3'd1;
    expect_idle("s10");
    chk("s10_active", 32'(thread_active_o), 32'h09);
    next(); start(3'd0, 32'h999);
    #1; chk("s11_active", 32'(thread_active_o), 32'h09);
    next(); retire(3'd0);
    #1; chk("s12_active", 32'(thread_active_o), 32'h09);
    next(); retire(3'd3);          expect_issue("s13", 3'd0, 32'h10C);
    next();                        expect_issue("s14", 3'd3, 32'h208);
    next(); retire(3'd0);          expect_idle("s15");
    next();                        expect_issue("s16", 3'd0, 32'h110);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(fetch_valid_o), 32'd0);
    chk("arst_pc", fetch_pc_o, 32'd0);
    chk("arst_active", 32'(thread_active_o), 32'd0);
    #1;
    rst_n = 1'b1;
    next(); start(3'd5, 32'h500);  expect_idle("s17");
    next();                        expect_issue("s18", 3'd5, 32'h500);

    // Fresh reset, then start all eight threads while the memory stall holds issue
    #1; rst_n = 1'b0;
    #1; rst_n = 1'b1;
    mem_req_m_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next();
      mpc[i] = 32'h1000 + 32'(i) * 32'h100;
      start(3'(i), mpc[i]);
      expect_idle("start_stalled");
    end
    next();
    mem_req_m_i = 1'b0;
    #1; chk("all_active", 32'(thread_active_o), 32'hFF);

    // Round-robin with one-cycle retire stub; tid 2 redirected while in flight
    for (int k = 0; k < 27; k++) begin
      if (k > 0) retire(3'((k - 1) % 8));
      if (k == 19) begin
        branch_taken_e_i  = 1'b1;
        branch_tid_e_i    = 3'd2;
        branch_target_e_i = 32'h400;
      end
      expect_issue("rr", 3'(k % 8), mpc[k % 8]);
      mpc[k % 8] = mpc[k % 8] + 32'd4;
      if (k == 19) mpc[2] = 32'h400;
      next();
    end

    // Three stall cycles, then release resumes at tid 3 in the same cycle
    retire(3'd2);
    mem_req_m_i = 1'b1; mem_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall", 32'(stall_o), 32'd1);
      chk("flush", 32'(flush_w_o), 32'd1);
      chk("stall_valid", 32'(fetch_valid_o), 32'd0);
      next();
    end
    mem_ready_i = 1'b1;
    #1; chk("release_stall", 32'(stall_o), 32'd0);
    expect_issue("release", 3'd3, mpc[3]);
    next();
    mem_req_m_i = 1'b0; mem_ready_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
